// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, byte or little-endian 16-bit access
// to a byte-wide data memory, with range checking and sign-extended byte loads.
module load_store_unit #(
  parameter int unsigned MEM_DEPTH = 32
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_wide,
  input  logic [7:0]  req_addr,
  input  logic [15:0] req_wdata,
  input  logic [2:0]  req_rd,
  output logic        signal_memread,
  output logic        signal_memwrite,
  output logic [7:0]  mem_address,
  output logic [7:0]  mem_data_to_write,
  input  logic [7:0]  mem_data_out,
  output logic        wb_valid,
  output logic [2:0]  wb_rd,
  output logic [15:0] wb_data,
  output logic        addr_error
);

  localparam int unsigned MAX_BYTE_ADDR = MEM_DEPTH - 1;
  localparam int unsigned MAX_WIDE_ADDR = MEM_DEPTH - 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACC_LO = 3'd1,
    ACC_HI = 3'd2,
    DONE   = 3'd3,
    ERR    = 3'd4
  } state_t;

  state_t      state, state_next;
  logic        r_write, r_wide;
  logic [7:0]  r_addr;
  logic [15:0] r_wdata;
  logic [2:0]  r_rd;
  logic [7:0]  lo_byte;
  logic        in_range;

  assign in_range = req_wide ? (32'(req_addr) <= MAX_WIDE_ADDR)
                             : (32'(req_addr) <= MAX_BYTE_ADDR);

  // State register
  always_ff @(posedge clock) begin
    if (clear) state <= IDLE;
    else       state <= state_next;
  end

  // Next state and memory/handshake strobes; clear masks every strobe
  always_comb begin
    state_next        = state;
    req_ready         = 1'b0;
    signal_memread    = 1'b0;
    signal_memwrite   = 1'b0;
    mem_address       = 8'd0;
    mem_data_to_write = 8'd0;
    wb_valid          = 1'b0;
    addr_error        = 1'b0;
    case (state)
      IDLE: begin
        req_ready = !clear;
        if (req_valid) state_next = in_range ? ACC_LO : ERR;
      end
      ACC_LO: begin
        mem_address       = r_addr;
        mem_data_to_write = r_wdata[7:0];
        signal_memwrite   = r_write && !clear;
        signal_memread    = !r_write && !clear;
        state_next        = r_wide ? ACC_HI : DONE;
      end
      ACC_HI: begin
        mem_address       = r_addr + 8'd1;
        mem_data_to_write = r_wdata[15:8];
        signal_memwrite   = r_write && !clear;
        signal_memread    = !r_write && !clear;
        state_next        = DONE;
      end
      DONE: begin
        wb_valid   = !r_write && !clear;
        state_next = IDLE;
      end
      ERR: begin
        addr_error = !clear;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request capture and load assembly; wb_data only moves on the last load byte
  always_ff @(posedge clock) begin
    if (clear) begin
      r_write <= 1'b0;
      r_wide  <= 1'b0;
      r_addr  <= 8'd0;
      r_wdata <= 16'd0;
      r_rd    <= 3'd0;
      lo_byte <= 8'd0;
      wb_data <= 16'd0;
      wb_rd   <= 3'd0;
    end else begin
      if (state == IDLE && req_valid) begin
        r_write <= req_write;
        r_wide  <= req_wide;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_rd    <= req_rd;
      end
      if (state == ACC_LO && !r_write) begin
        lo_byte <= mem_data_out;
        if (!r_wide) begin
          wb_data <= {{8{mem_data_out[7]}}, mem_data_out};
          wb_rd   <= r_rd;
        end
      end
      if (state == ACC_HI && !r_write) begin
        wb_data <= {mem_data_out, lo_byte};
        wb_rd   <= r_rd;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized scoreboard bench for load_store_unit with a byte-array memory
// and a transaction-level reference model.
module tb_load_store_unit;

  localparam int unsigned MEM_DEPTH = 32;

  logic        clock;
  logic        clear;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic        req_wide;
  logic [7:0]  req_addr;
  logic [15:0] req_wdata;
  logic [2:0]  req_rd;
  logic        signal_memread;
  logic        signal_memwrite;
  logic [7:0]  mem_address;
  logic [7:0]  mem_data_to_write;
  logic [7:0]  mem_data_out;
  logic        wb_valid;
  logic [2:0]  wb_rd;
  logic [15:0] wb_data;
  logic        addr_error;

  load_store_unit #(.MEM_DEPTH(MEM_DEPTH)) dut (
    .clock             (clock),
    .clear             (clear),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_write         (req_write),
    .req_wide          (req_wide),
    .req_addr          (req_addr),
    .req_wdata         (req_wdata),
    .req_rd            (req_rd),
    .signal_memread    (signal_memread),
    .signal_memwrite   (signal_memwrite),
    .mem_address       (mem_address),
    .mem_data_to_write (mem_data_to_write),
    .mem_data_out      (mem_data_out),
    .wb_valid          (wb_valid),
    .wb_rd             (wb_rd),
    .wb_data           (wb_data),
    .addr_error        (addr_error)
  );

  typedef struct {
    bit          is_err;
    logic [2:0]  rd;
    logic [15:0] data;
    int          due;
  } exp_t;

  typedef struct {
    bit         wr;
    logic [7:0] addr;
    logic [7:0] data;
  } acc_t;

  exp_t        exp_q[$];
  acc_t        acc_q[$];
  logic [7:0]  mem     [256];
  logic [7:0]  ref_mem [256];
  int          cyc;
  int          n_total;
  int          n_pass;
  logic [15:0] hold_data;
  logic [2:0]  hold_rd;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  // Behavioural data memory seen by the DUT
  assign mem_data_out = mem[mem_address];
  always @(posedge clock) if (signal_memwrite) mem[mem_address] <= mem_data_to_write;

  always @(posedge clock) if (clear) begin
    hold_data <= 16'd0;
    hold_rd   <= 3'd0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: pops expected write-backs/errors and memory accesses as the DUT shows them
  always @(negedge clock) begin
    exp_t e;
    acc_t a;
    if (wb_valid || addr_error) begin
      if (exp_q.size() == 0) begin
        check("unexpected_response", {30'd0, wb_valid, addr_error}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("resp_kind", {30'd0, wb_valid, addr_error}, e.is_err ? 32'd1 : 32'd2);
        check("resp_cycle", 32'(cyc), 32'(e.due));
        if (!e.is_err) begin
          check("wb_data", 32'(wb_data), 32'(e.data));
          check("wb_rd", 32'(wb_rd), 32'(e.rd));
          hold_data <= e.data;
          hold_rd   <= e.rd;
        end
      end
    end
    if (!wb_valid) begin
      check("wb_hold", {13'd0, wb_rd, wb_data}, {13'd0, hold_rd, hold_data});
    end
    if (signal_memread || signal_memwrite) begin
      if (acc_q.size() == 0) begin
        check("unexpected_access", {30'd0, signal_memread, signal_memwrite}, 32'd0);
      end else begin
        a = acc_q.pop_front();
        check("acc_strobes", {30'd0, signal_memread, signal_memwrite}, a.wr ? 32'd1 : 32'd2);
        check("acc_addr", 32'(mem_address), 32'(a.addr));
        if (a.wr) check("acc_wdata", 32'(mem_data_to_write), 32'(a.data));
      end
    end else if (!clear) begin
      check("idle_bus", {16'd0, mem_address, mem_data_to_write}, 32'd0);
    end
  end

  // Drive a request and record the model's expected outcome at the handshake
  task automatic issue(input bit w, input bit wd, input logic [7:0] a,
                       input logic [15:0] d, input logic [2:0] rd);
    int   n;
    int   nbytes;
    int   v;
    exp_t e;
    acc_t ac;
    req_write = w;
    req_wide  = wd;
    req_addr  = a;
    req_wdata = d;
    req_rd    = rd;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (!req_ready) begin
      check("ready_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    nbytes = wd ? 2 : 1;
    if (int'(a) + nbytes > int'(MEM_DEPTH)) begin
      e.is_err = 1'b1;
      e.rd     = 3'd0;
      e.data   = 16'd0;
      e.due    = cyc + 1;
      exp_q.push_back(e);
    end else begin
      for (int k = 0; k < nbytes; k++) begin
        ac.wr   = w;
        ac.addr = a + 8'(k);
        ac.data = (k == 0) ? d[7:0] : d[15:8];
        acc_q.push_back(ac);
        if (w) ref_mem[int'(a) + k] = ac.data;
      end
      if (!w) begin
        if (wd) v = int'(ref_mem[int'(a) + 1]) * 256 + int'(ref_mem[a]);
        else begin
          v = int'(ref_mem[a]);
          if (v >= 128) v = v + 65280;
        end
        e.is_err = 1'b0;
        e.rd     = rd;
        e.data   = 16'(v);
        e.due    = cyc + nbytes + 1;
        exp_q.push_back(e);
      end
    end
    @(negedge clock);
  endtask

  task automatic drain();
    int n;
    req_valid = 1'b0;
    n = 0;
    while ((exp_q.size() != 0 || acc_q.size() != 0) && n < 60) begin
      @(negedge clock);
      n++;
    end
    check("drain_empty", 32'(exp_q.size() + acc_q.size()), 32'd0);
    repeat (2) @(negedge clock);
  endtask

  initial begin
    cyc       = 0;
    n_total   = 0;
    n_pass    = 0;
    hold_data = 16'd0;
    hold_rd   = 3'd0;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 8'(i);
      ref_mem[i] = 8'(i);
    end
    mem[17]     = 8'hFF;
    ref_mem[17] = 8'hFF;

    clear     = 1'b1;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_wide  = 1'b0;
    req_addr  = 8'd2;
    req_wdata = 16'd0;
    req_rd    = 3'd0;
    repeat (2) @(negedge clock);
    check("reset_ready", 32'(req_ready), 32'd0);
    check("reset_outs", {28'd0, signal_memread, signal_memwrite, wb_valid, addr_error}, 32'd0);
    check("reset_wb", {13'd0, wb_rd, wb_data}, 32'd0);
    req_valid = 1'b0;
    clear     = 1'b0;
    @(negedge clock);
    check("ready_after_reset", 32'(req_ready), 32'd1);

    issue(1'b0, 1'b0, 8'd17, 16'd0, 3'd1);
    drain();
    issue(1'b0, 1'b1, 8'd4, 16'd0, 3'd2);
    drain();
    issue(1'b1, 1'b0, 8'd3, 16'h005A, 3'd0);
    issue(1'b0, 1'b0, 8'd3, 16'd0, 3'd6);
    drain();
    issue(1'b0, 1'b1, 8'd31, 16'd0, 3'd3);
    issue(1'b1, 1'b0, 8'd40, 16'h1234, 3'd0);
    drain();
    check("ready_after_err", 32'(req_ready), 32'd1);
    issue(1'b0, 1'b1, 8'd30, 16'd0, 3'd5);
    issue(1'b0, 1'b0, 8'd31, 16'd0, 3'd4);
    drain();

    // Wide store aborted by clear while the high byte is on the bus
    issue(1'b1, 1'b1, 8'd8, 16'hBEEF, 3'd0);
    req_valid   = 1'b0;
    ref_mem[9]  = 8'h09;
    void'(acc_q.pop_back());
    @(posedge clock);
    #1 clear = 1'b1;
    @(posedge clock);
    #1 clear = 1'b0;
    @(negedge clock);
    check("abort_ready", 32'(req_ready), 32'd1);
    check("abort_wb", {13'd0, wb_rd, wb_data}, 32'd0);
    check("abort_mem8", 32'(mem[8]), 32'h0000_00EF);
    check("abort_mem9", 32'(mem[9]), 32'h0000_0009);
    drain();

    // Back-to-back byte loads with req_valid held high
    issue(1'b0, 1'b0, 8'd1, 16'd0, 3'd1);
    issue(1'b0, 1'b0, 8'd2, 16'd0, 3'd2);
    drain();

    for (int t = 0; t < 250; t++) begin
      issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            8'($urandom_range(0, 35)), 16'($urandom), 3'($urandom_range(0, 7)));
      if ($urandom_range(0, 1) == 1) begin
        req_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clock);
      end
    end
    drain();

    for (int i = 0; i < int'(MEM_DEPTH); i++) begin
      check($sformatf("mem[%0d]", i), 32'(mem[i]), 32'(ref_mem[i]));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
